// File: rtl/proc_pkg.sv
// Shared fetch-stage definitions: reset PC, next-PC source selector and alignment helper.
package proc_pkg;

    localparam logic [31:0] PC_RESET_VAL = 32'h0000_0000;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INCR,
        PC_REDIR,
        PC_TRAP,
        PC_RESET
    } pc_sel_e;

    // A target is aligned when its low log2(incr) bits are zero; incr is a power of two.
    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned incr);
        logic [63:0] mask;
        mask = 64'(incr) - 64'd1;
        return (addr & mask) == '0;
    endfunction

endpackage

// File: rtl/pc_hist_pipe.sv
// Shift-register history of past PCs with per-stage valid bits.
module pc_hist_pipe
    import proc_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HIST_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       adv_i,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            pc_i,
    output logic [HIST_DEPTH*XLEN-1:0] hist_o,
    output logic [HIST_DEPTH-1:0]      vld_o
);

    logic [HIST_DEPTH-1:0][XLEN-1:0] hist_q;
    logic [HIST_DEPTH-1:0]           vld_q;

    // A flush still shifts the current PC in, but marks every stage invalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            vld_q  <= '0;
        end else if (adv_i || flush_i) begin
            hist_q[0] <= pc_i;
            vld_q[0]  <= !flush_i;
            for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
                hist_q[k] <= hist_q[k-1];
                vld_q[k]  <= vld_q[k-1] && !flush_i;
            end
        end
    end

    assign hist_o = hist_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: increment, redirect, trap vectoring, stall and misaligned-target capture.
module pc_gen
    import proc_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VAL  = XLEN'(PC_RESET_VAL),
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h0000_0100),
    parameter int unsigned     INCR       = 4,
    parameter int unsigned     HIST_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       incr_pc_i,
    input  logic                       stall_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    input  logic                       trap_i,
    output logic [XLEN-1:0]            pc_o,
    output logic [HIST_DEPTH*XLEN-1:0] pc_hist_o,
    output logic [HIST_DEPTH-1:0]      pc_hist_vld_o,
    output logic                       misalign_o,
    output logic [XLEN-1:0]            bad_addr_o
);

    pc_sel_e         pc_sel;
    logic            redir_aligned;
    logic            misalign_req;
    logic            adv;
    logic            flush;
    logic [XLEN-1:0] pc_next;

    assign redir_aligned = is_aligned(64'(redirect_pc_i), INCR);

    always_comb begin
        pc_sel       = PC_HOLD;
        misalign_req = 1'b0;
        if (rst_i) begin
            pc_sel = PC_RESET;
        end else if (trap_i) begin
            pc_sel = PC_TRAP;
        end else if (redirect_i) begin
            if (redir_aligned) begin
                pc_sel = PC_REDIR;
            end else begin
                misalign_req = 1'b1;
            end
        end else if (stall_i) begin
            pc_sel = PC_HOLD;
        end else if (incr_pc_i) begin
            pc_sel = PC_INCR;
        end
    end

    always_comb begin
        pc_next = pc_o;
        case (pc_sel)
            PC_RESET: pc_next = RESET_VAL;
            PC_TRAP:  pc_next = TRAP_VEC;
            PC_REDIR: pc_next = redirect_pc_i;
            PC_INCR:  pc_next = pc_o + XLEN'(INCR);
            default:  pc_next = pc_o;
        endcase
    end

    assign adv   = (pc_sel == PC_INCR) || (pc_sel == PC_REDIR) || (pc_sel == PC_TRAP);
    assign flush = !rst_i && (trap_i || redirect_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_o       <= RESET_VAL;
            misalign_o <= 1'b0;
            bad_addr_o <= '0;
        end else begin
            pc_o       <= pc_next;
            misalign_o <= misalign_req;
            if (misalign_req) begin
                bad_addr_o <= redirect_pc_i;
            end
        end
    end

    pc_hist_pipe #(
        .XLEN       (XLEN),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .adv_i   (adv),
        .flush_i (flush),
        .pc_i    (pc_o),
        .hist_o  (pc_hist_o),
        .vld_o   (pc_hist_vld_o)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a cycle-by-cycle reference model and literal spot checks.
module tb_pc_gen;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;

    logic              clk = 1'b0;
    logic              rst, incr, stall, redir, trap;
    logic [XLEN-1:0]   rpc;
    logic [XLEN-1:0]   pc;
    logic [DEPTH*XLEN-1:0] hist;
    logic [DEPTH-1:0]  vld;
    logic              mis;
    logic [XLEN-1:0]   bad;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN       (XLEN),
        .RESET_VAL  (RV),
        .TRAP_VEC   (TV),
        .INCR       (4),
        .HIST_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .incr_pc_i     (incr),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .trap_i        (trap),
        .pc_o          (pc),
        .pc_hist_o     (hist),
        .pc_hist_vld_o (vld),
        .misalign_o    (mis),
        .bad_addr_o    (bad)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural rules applied to the inputs seen at each edge.
    logic [31:0] m_pc, m_bad;
    logic [31:0] m_hist [DEPTH];
    logic        m_vld  [DEPTH];
    logic        m_mis;
    bit          m_live = 0;

    function automatic void m_push(input logic [31:0] p, input bit flushing);
        for (int k = DEPTH - 1; k > 0; k--) begin
            m_hist[k] = m_hist[k-1];
            m_vld[k]  = m_vld[k-1];
        end
        m_hist[0] = p;
        m_vld[0]  = 1'b1;
        if (flushing) for (int k = 0; k < DEPTH; k++) m_vld[k] = 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RV; m_mis = 0; m_bad = 0; m_live = 1;
            for (int k = 0; k < DEPTH; k++) begin m_hist[k] = 0; m_vld[k] = 0; end
        end else if (m_live) begin
            m_mis = 0;
            if (trap) begin
                m_push(m_pc, 1); m_pc = TV;
            end else if (redir) begin
                m_push(m_pc, 1);
                if (rpc % 4 == 0) m_pc = rpc;
                else begin m_mis = 1; m_bad = rpc; end
            end else if (!stall && incr) begin
                m_push(m_pc, 0);
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            end
        end
        #1;
        if (m_live) begin
            check("model_pc", 64'(pc), 64'(m_pc));
            check("model_hist0", 64'(hist[31:0]), 64'(m_hist[0]));
            check("model_hist1", 64'(hist[63:32]), 64'(m_hist[1]));
            check("model_vld", 64'(vld), 64'({m_vld[1], m_vld[0]}));
            check("model_mis", 64'(mis), 64'(m_mis));
            check("model_bad", 64'(bad), 64'(m_bad));
        end
    end

    task automatic cyc(input logic r, input logic i, input logic s,
                       input logic d, input logic [31:0] a, input logic t);
        @(negedge clk);
        rst = r; incr = i; stall = s; redir = d; rpc = a; trap = t;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; incr = 0; stall = 0; redir = 0; rpc = 0; trap = 0;
        // T1 reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("t1_pc", 64'(pc), 64'h0);
        check("t1_vld", 64'(vld), 64'h0);
        check("t1_mis", 64'(mis), 64'h0);
        // T2 increment
        cyc(0, 1, 0, 0, 0, 0);
        check("t2_pc4", 64'(pc), 64'h4);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("t2_pcC", 64'(pc), 64'hC);
        check("t2_hist0", 64'(hist[31:0]), 64'h8);
        check("t2_hist1", 64'(hist[63:32]), 64'h4);
        check("t2_vld", 64'(vld), 64'h3);
        // T3 stall beats incr
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        check("t3_pc", 64'(pc), 64'hC);
        check("t3_hist0", 64'(hist[31:0]), 64'h8);
        check("t3_vld", 64'(vld), 64'h3);
        // T4 redirect (with stall) and trap+redirect
        cyc(0, 1, 1, 1, 32'h200, 0);
        check("t4_pc", 64'(pc), 64'h200);
        check("t4_vld", 64'(vld), 64'h0);
        check("t4_hist0", 64'(hist[31:0]), 64'hC);
        cyc(0, 1, 0, 0, 0, 0);
        check("t4_vld_after_incr", 64'(vld), 64'h1);
        cyc(0, 0, 0, 1, 32'h203, 1);
        check("t4_trap", 64'(pc), 64'h100);
        check("t4_trap_mis", 64'(mis), 64'h0);
        // T5 misaligned redirect, back-to-back
        cyc(0, 0, 0, 1, 32'h40, 0);
        cyc(0, 1, 0, 1, 32'h202, 0);
        check("t5_pc", 64'(pc), 64'h40);
        check("t5_mis", 64'(mis), 64'h1);
        check("t5_bad", 64'(bad), 64'h202);
        cyc(0, 0, 0, 1, 32'h41, 0);
        check("t5_mis2", 64'(mis), 64'h1);
        check("t5_bad2", 64'(bad), 64'h41);
        cyc(0, 0, 0, 0, 0, 0);
        check("t5_mis_drop", 64'(mis), 64'h0);
        check("t5_bad_hold", 64'(bad), 64'h41);
        // T6 wrap and reset mid-operation
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("t6_wrap", 64'(pc), 64'h0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 32'h300, 1);
        check("t6_rst_pc", 64'(pc), 64'h0);
        check("t6_rst_hist", 64'(hist), 64'h0);
        check("t6_rst_vld", 64'(vld), 64'h0);
        cyc(0, 1, 0, 0, 0, 0);
        check("t6_post_pc", 64'(pc), 64'h4);
        check("t6_post_vld", 64'(vld), 64'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
